// File: rtl/store_monitor.sv
// Self-check monitor for the RV32i data-memory write port: classifies each store
// as pass, fail or allowed scratch, and raises a sticky verdict or a timeout.
module store_monitor #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned MW_W      = 2,
   parameter int unsigned PASS_ADDR = 100,
   parameter int unsigned PASS_DATA = 25,
   parameter int unsigned SCR_BASE  = 96,
   parameter int unsigned SCR_SIZE  = 4,
   parameter int unsigned TIMEOUT   = 1000,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic [MW_W-1:0]   MemWrite,
   input  logic [ADDR_W-1:0] DataAdr,
   input  logic [DATA_W-1:0] WriteData,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic [1:0]        fail_code,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic [CNT_W-1:0]  store_count
);

   typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TMO} state_e;

   localparam logic [1:0] FC_NONE = 2'd0;
   localparam logic [1:0] FC_ADDR = 2'd1;
   localparam logic [1:0] FC_DATA = 2'd2;
   localparam logic [1:0] FC_TMO  = 2'd3;

   localparam logic [ADDR_W-1:0] PASS_A = ADDR_W'(PASS_ADDR);
   localparam logic [DATA_W-1:0] PASS_D = DATA_W'(PASS_DATA);
   // One extra bit keeps the window end from wrapping at the top of the address space.
   localparam logic [ADDR_W:0]   WIN_LO = (ADDR_W+1)'(SCR_BASE);
   localparam logic [ADDR_W:0]   WIN_HI = WIN_LO + (ADDR_W+1)'(SCR_SIZE);
   localparam bit                TMO_EN = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0]  TMO_AT = TMO_EN ? CNT_W'(TIMEOUT - 1) : '0;

   state_e              state_q, state_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic                fail_q, fail_d;
   logic [1:0]          fail_code_q, fail_code_d;
   logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
   logic [DATA_W-1:0]   fail_data_q, fail_data_d;
   logic [CNT_W-1:0]    store_count_q, store_count_d;
   logic [CNT_W-1:0]    cyc_q, cyc_d;

   logic is_store, hit_pass, data_ok, in_win, tmo_hit;

   always_comb begin
      is_store = |MemWrite;
      hit_pass = (DataAdr == PASS_A);
      data_ok  = (WriteData == PASS_D);
      in_win   = ({1'b0, DataAdr} >= WIN_LO) && ({1'b0, DataAdr} < WIN_HI);
      tmo_hit  = TMO_EN && (cyc_q >= TMO_AT);
   end

   always_comb begin
      state_d       = state_q;
      done_d        = done_q;
      pass_d        = pass_q;
      fail_d        = fail_q;
      fail_code_d   = fail_code_q;
      fail_addr_d   = fail_addr_q;
      fail_data_d   = fail_data_q;
      store_count_d = store_count_q;
      cyc_d         = cyc_q;

      if (clear) begin
         state_d       = ST_RUN;
         done_d        = 1'b0;
         pass_d        = 1'b0;
         fail_d        = 1'b0;
         fail_code_d   = FC_NONE;
         fail_addr_d   = '0;
         fail_data_d   = '0;
         store_count_d = '0;
         cyc_d         = '0;
      end else if (state_q == ST_RUN) begin
         if (is_store && hit_pass) begin
            done_d = 1'b1;
            if (data_ok) begin
               state_d = ST_PASS;
               pass_d  = 1'b1;
            end else begin
               state_d     = ST_FAIL;
               fail_d      = 1'b1;
               fail_code_d = FC_DATA;
               fail_addr_d = DataAdr;
               fail_data_d = WriteData;
            end
         end else if (is_store && !in_win) begin
            state_d     = ST_FAIL;
            done_d      = 1'b1;
            fail_d      = 1'b1;
            fail_code_d = FC_ADDR;
            fail_addr_d = DataAdr;
            fail_data_d = WriteData;
         end else begin
            // Idle or scratch store: the run keeps going, so the watchdog keeps ticking.
            if (is_store && (store_count_q != '1))
               store_count_d = store_count_q + 1'b1;
            if (cyc_q != '1)
               cyc_d = cyc_q + 1'b1;
            if (tmo_hit) begin
               state_d     = ST_TMO;
               done_d      = 1'b1;
               fail_d      = 1'b1;
               fail_code_d = FC_TMO;
               fail_addr_d = '0;
               fail_data_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_RUN;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         fail_q        <= 1'b0;
         fail_code_q   <= FC_NONE;
         fail_addr_q   <= '0;
         fail_data_q   <= '0;
         store_count_q <= '0;
         cyc_q         <= '0;
      end else begin
         state_q       <= state_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         fail_q        <= fail_d;
         fail_code_q   <= fail_code_d;
         fail_addr_q   <= fail_addr_d;
         fail_data_q   <= fail_data_d;
         store_count_q <= store_count_d;
         cyc_q         <= cyc_d;
      end
   end

   assign done        = done_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign fail_code   = fail_code_q;
   assign fail_addr   = fail_addr_q;
   assign fail_data   = fail_data_q;
   assign store_count = store_count_q;

endmodule

// File: tb/tb_store_monitor.sv
// Bench for store_monitor: directed scenarios plus random stores, two instances
// (default timeout and a short one) checked against a verdict-level model.
module tb_store_monitor;

   localparam int unsigned P_ADDR = 100;
   localparam int unsigned P_DATA = 25;
   localparam int unsigned S_BASE = 96;
   localparam int unsigned S_SIZE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clear = 1'b0;
   logic [1:0]  MemWrite = '0;
   logic [31:0] DataAdr = '0;
   logic [31:0] WriteData = '0;

   logic        d0_done, d0_pass, d0_fail, d1_done, d1_pass, d1_fail;
   logic [1:0]  d0_code, d1_code;
   logic [31:0] d0_addr, d0_data, d1_addr, d1_data;
   logic [15:0] d0_cnt, d1_cnt;

   always #5 clk = ~clk;

   store_monitor u_dut (
      .clk(clk), .rst(rst), .clear(clear), .MemWrite(MemWrite), .DataAdr(DataAdr),
      .WriteData(WriteData), .done(d0_done), .pass(d0_pass), .fail(d0_fail),
      .fail_code(d0_code), .fail_addr(d0_addr), .fail_data(d0_data), .store_count(d0_cnt));

   store_monitor #(.TIMEOUT(10)) u_tmo (
      .clk(clk), .rst(rst), .clear(clear), .MemWrite(MemWrite), .DataAdr(DataAdr),
      .WriteData(WriteData), .done(d1_done), .pass(d1_pass), .fail(d1_fail),
      .fail_code(d1_code), .fail_addr(d1_addr), .fail_data(d1_data), .store_count(d1_cnt));

   // Reference: verdict plus counters, per instance.
   int unsigned m_to [2] = '{1000, 10};
   bit          m_done [2];
   bit          m_pass [2];
   int unsigned m_code [2];
   int unsigned m_addr [2];
   int unsigned m_data [2];
   int unsigned m_cnt  [2];
   int unsigned m_cyc  [2];

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
   endtask

   task automatic model_clear(input int i);
      m_done[i] = 0; m_pass[i] = 0; m_code[i] = 0; m_addr[i] = 0;
      m_data[i] = 0; m_cnt[i] = 0; m_cyc[i] = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) model_clear(i);
   endtask

   task automatic verdict_fail(input int i, input int unsigned code,
                               input int unsigned a, input int unsigned d);
      m_done[i] = 1; m_code[i] = code; m_addr[i] = a; m_data[i] = d;
   endtask

   task automatic model_step();
      bit st, timed;
      st = (MemWrite != 0);
      for (int i = 0; i < 2; i++) begin
         if (!rst || clear) model_clear(i);
         else if (!m_done[i]) begin
            if (st && DataAdr == P_ADDR) begin
               if (WriteData == P_DATA) begin m_done[i] = 1; m_pass[i] = 1; end
               else verdict_fail(i, 2, DataAdr, WriteData);
            end else if (st && !(longint'(DataAdr) >= longint'(S_BASE) &&
                                 longint'(DataAdr) < longint'(S_BASE) + longint'(S_SIZE))) begin
               verdict_fail(i, 1, DataAdr, WriteData);
            end else begin
               timed = (m_to[i] != 0) && (m_cyc[i] + 1 >= m_to[i]);
               if (st && m_cnt[i] < 65535) m_cnt[i]++;
               if (m_cyc[i] < 65535) m_cyc[i]++;
               if (timed) verdict_fail(i, 3, 0, 0);
            end
         end
      end
   endtask

   task automatic check_all();
      chk("u0.done", d0_done, m_done[0]);
      chk("u0.pass", d0_pass, m_pass[0]);
      chk("u0.fail", d0_fail, m_done[0] & ~m_pass[0]);
      chk("u0.code", d0_code, m_code[0]);
      chk("u0.addr", d0_addr, m_addr[0]);
      chk("u0.data", d0_data, m_data[0]);
      chk("u0.cnt",  d0_cnt,  m_cnt[0]);
      chk("u1.done", d1_done, m_done[1]);
      chk("u1.pass", d1_pass, m_pass[1]);
      chk("u1.fail", d1_fail, m_done[1] & ~m_pass[1]);
      chk("u1.code", d1_code, m_code[1]);
      chk("u1.addr", d1_addr, m_addr[1]);
      chk("u1.data", d1_data, m_data[1]);
      chk("u1.cnt",  d1_cnt,  m_cnt[1]);
   endtask

   // Inputs are already set (posedge+2); model the coming edge, then sample after it.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #2;
      check_all();
   endtask

   task automatic store(input logic [1:0] mw, input logic [31:0] a, input logic [31:0] d);
      MemWrite = mw; DataAdr = a; WriteData = d;
      cycle();
      MemWrite = '0;
   endtask

   task automatic idle(input int n);
      MemWrite = '0;
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic do_reset();
      MemWrite = '0; clear = 1'b0;
      rst = 1'b0;
      model_reset();
      #1;
      check_all();
      cycle();
      cycle();
      rst = 1'b1;
   endtask

   initial begin
      int r;
      @(posedge clk); #2;

      // reset state and a single pass store
      do_reset();
      chk("rst.done", d0_done, 1'b0);
      chk("rst.cnt", d0_cnt, 16'd0);
      store(2'd1, 32'd100, 32'd25);
      chk("pass1.done", d0_done, 1'b1);
      chk("pass1.pass", d0_pass, 1'b1);
      chk("pass1.fail", d0_fail, 1'b0);
      chk("pass1.code", d0_code, 2'd0);

      // scratch stores then pass
      do_reset();
      store(2'd2, 32'd96, 32'd5);
      store(2'd3, 32'd97, 32'd6);
      store(2'd1, 32'd99, 32'd7);
      chk("scr.cnt", d0_cnt, 16'd3);
      chk("scr.done", d0_done, 1'b0);
      store(2'd1, 32'd100, 32'd25);
      chk("scr.pass", d0_pass, 1'b1);

      // wrong pass data, then a later good store is ignored
      do_reset();
      store(2'd1, 32'd100, 32'd24);
      chk("bad.fail", d0_fail, 1'b1);
      chk("bad.code", d0_code, 2'd2);
      chk("bad.addr", d0_addr, 32'd100);
      chk("bad.data", d0_data, 32'd24);
      store(2'd1, 32'd100, 32'd25);
      chk("sticky.pass", d0_pass, 1'b0);
      chk("sticky.code", d0_code, 2'd2);

      // out-of-window store, clear, then pass
      do_reset();
      store(2'd1, 32'd104, 32'd7);
      chk("oow.code", d0_code, 2'd1);
      chk("oow.addr", d0_addr, 32'd104);
      chk("oow.data", d0_data, 32'd7);
      clear = 1'b1;
      store(2'd1, 32'd100, 32'd25);
      clear = 1'b0;
      chk("clr.done", d0_done, 1'b0);
      chk("clr.cnt", d0_cnt, 16'd0);
      store(2'd1, 32'd100, 32'd25);
      chk("clr.pass", d0_pass, 1'b1);

      // timeout of 10 on the second instance
      do_reset();
      idle(9);
      chk("tmo.pre", d1_done, 1'b0);
      idle(1);
      chk("tmo.fail", d1_fail, 1'b1);
      chk("tmo.code", d1_code, 2'd3);
      do_reset();
      idle(9);
      store(2'd1, 32'd100, 32'd25);
      chk("tmo.race.pass", d1_pass, 1'b1);
      chk("tmo.race.fail", d1_fail, 1'b0);

      // async reset mid-cycle after a fail
      do_reset();
      store(2'd1, 32'd104, 32'd7);
      #1;
      rst = 1'b0;
      model_reset();
      #1;
      chk("arst.done", d0_done, 1'b0);
      chk("arst.code", d0_code, 2'd0);
      chk("arst.addr", d0_addr, 32'd0);
      chk("arst.data", d0_data, 32'd0);
      check_all();
      cycle();
      rst = 1'b1;

      // random traffic
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 99);
         rst   = (r >= 2);
         clear = (r >= 2 && r < 10);
         MemWrite = 2'($urandom_range(0, 3));
         r = $urandom_range(0, 99);
         if (r < 60)      DataAdr = 32'd96 + 32'($urandom_range(0, 3));
         else if (r < 75) DataAdr = 32'd100;
         else if (r < 90) DataAdr = 32'($urandom_range(90, 110));
         else             DataAdr = $urandom;
         WriteData = ($urandom_range(0, 1) != 0) ? 32'd25 : 32'($urandom_range(0, 30));
         if (!rst) model_reset();
         cycle();
      end
      rst = 1'b1; clear = 1'b0; MemWrite = '0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
